axis_wb_req_arbiter: RTL
========================

Name: axis_wb_req_arbiter

Overview:
- Shares the single AXI-stream command port of the AXI-stream-to-Wishbone bridge among NUM_REQ requesters.
- Arbitrates round-robin at packet granularity: a grant is held from the first beat to the tlast beat.
- Records each granted requester ID in an in-order ID FIFO, which steers bridge response packets back to the requester that issued the command.
- Sits between the requester agents and the bridge's input_axis/output_axis ports.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- AXIS_DATA_WIDTH, 8, stream data width
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width
- ID_FIFO_DEPTH, 4, outstanding-command capacity (power of 2, >=2)

Ports:
- clock  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-low reset
- s_req_tdata  in  NUM_REQ*AXIS_DATA_WIDTH  per-requester command data, requester i at slice i
- s_req_tkeep  in  NUM_REQ*AXIS_KEEP_WIDTH  per-requester tkeep
- s_req_tvalid  in  NUM_REQ  per-requester valid
- s_req_tready  out  NUM_REQ  per-requester ready
- s_req_tlast  in  NUM_REQ  per-requester last
- s_req_tuser  in  NUM_REQ  per-requester user
- m_req_tdata/tkeep/tvalid/tlast/tuser  out  W/K/1/1/1  command stream to the bridge input
- m_req_tready  in  1  bridge input ready
- s_resp_tdata/tkeep/tvalid/tlast/tuser  in  W/K/1/1/1  response stream from the bridge output
- s_resp_tready  out  1  ready toward the bridge output
- m_resp_tdata  out  W  response data, broadcast to all requesters
- m_resp_tkeep  out  K  response tkeep, broadcast
- m_resp_tlast  out  1  response last, broadcast
- m_resp_tuser  out  1  response user, broadcast
- m_resp_tvalid  out  NUM_REQ  one-hot response valid
- m_resp_tready  in  NUM_REQ  per-requester response ready
- grant_id  out  $clog2(NUM_REQ)  currently or last granted requester
- grant_active  out  1  high in FWD
- outstanding  out  $clog2(ID_FIFO_DEPTH)+1  ID FIFO occupancy

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-low (reset).
- Reset values:
  - all tvalid and tready outputs 0
  - grant_id 0, grant_active 0, outstanding 0
  - round-robin pointer set so requester 0 has highest priority
  - FSM in IDLE
- FSM states: IDLE, FWD.
- IDLE:
  - If any s_req_tvalid is high and the ID FIFO is not full, register grant_id = first requester with tvalid, searching from (last+1) mod NUM_REQ.
  - In the same cycle, push grant_id into the ID FIFO and go to FWD.
  - Latency: a request seen in cycle N is forwarded from cycle N+1.
  - If the FIFO is full, stay in IDLE; all s_req_tready = 0.
- FWD:
  - m_req_* = s_req_*[grant_id], combinationally.
  - s_req_tready[grant_id] = m_req_tready; all other s_req_tready = 0.
  - On a beat with tvalid & tready & tlast: update last := grant_id and go to IDLE.
  - No back-to-back grant in that cycle: there is one idle cycle between packets.
- Framing:
  - Zero-beat packets do not exist.
  - Packet length is unbounded; the grant persists until tlast.
- Response path:
  - When the FIFO is non-empty, head ID h selects the destination.
  - m_resp_tvalid = onehot(h) & s_resp_tvalid.
  - s_resp_tready = m_resp_tready[h].
  - Data, keep, last and user pass through combinationally.
  - On an accepted response tlast beat, pop the FIFO.
  - When the FIFO is empty: s_resp_tready = 0, m_resp_tvalid = 0. Unsolicited responses stall and are never dropped.
- ID FIFO and outstanding:
  - A push and a pop in the same cycle leave outstanding unchanged.
  - outstanding = push count − pop count, within the range 0..ID_FIFO_DEPTH.
  - Read/write pointers wrap modulo ID_FIFO_DEPTH.
- Mid-operation reset:
  - A reset during FWD or an in-flight response aborts it immediately.
  - The FIFO is cleared and the FSM returns to IDLE the next cycle.
  - The arbiter does not emit a terminating tlast.
- Stability: the grant never changes mid-packet, even if the granted requester's tvalid drops between beats.

Test Plan:
- Single command: requester 1 sends 3 beats A2,10,20 (tlast on 20) with m_req_tready = 1 → m_req shows A2,10,20 in cycles 2-4; grant_id = 1; outstanding = 1. Bridge response A4,00 → m_resp_tvalid = 0b10 for 2 beats; outstanding = 0.
- Round-robin: all of 3 requesters hold 2-beat packets continuously, 6 packets → grant order 0,1,2,0,1,2; exactly 1 idle cycle between packets.
- Response steering: grants in order 2,0,1 → three bridge response packets are delivered to requesters 2, 0, 1 in that order. Holding m_resp_tready[0] = 0 for 5 cycles stalls s_resp_tready and data is held unchanged.
- FIFO full: ID_FIFO_DEPTH = 4, 4 commands granted with no responses → outstanding = 4 and a 5th request sees s_req_tready = 0. One response popped → the 5th is granted next cycle.
- Backpressure: m_req_tready toggles 1,0,0,1 during a 4-beat packet → beats are not lost or duplicated, and the grant is held.
- Reset mid-packet: reset = 0 after beat 2 of 4 → next cycle all tvalid = 0 and outstanding = 0. After release, a new request from requester 0 is granted first.

Source files
------------

// File: rtl/axis_wb_req_arbiter.sv
// Packet-level round-robin arbiter that shares one AXI-stream command port among NUM_REQ requesters
// and steers response packets back to their issuers through an in-order ID FIFO.
module axis_wb_req_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int AXIS_DATA_WIDTH = 8,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int ID_FIFO_DEPTH   = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_REQ*AXIS_DATA_WIDTH-1:0]   s_req_tdata,
  input  logic [NUM_REQ*AXIS_KEEP_WIDTH-1:0]   s_req_tkeep,
  input  logic [NUM_REQ-1:0]                   s_req_tvalid,
  output logic [NUM_REQ-1:0]                   s_req_tready,
  input  logic [NUM_REQ-1:0]                   s_req_tlast,
  input  logic [NUM_REQ-1:0]                   s_req_tuser,
  output logic [AXIS_DATA_WIDTH-1:0]           m_req_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]           m_req_tkeep,
  output logic                                 m_req_tvalid,
  input  logic                                 m_req_tready,
  output logic                                 m_req_tlast,
  output logic                                 m_req_tuser,
  input  logic [AXIS_DATA_WIDTH-1:0]           s_resp_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]           s_resp_tkeep,
  input  logic                                 s_resp_tvalid,
  output logic                                 s_resp_tready,
  input  logic                                 s_resp_tlast,
  input  logic                                 s_resp_tuser,
  output logic [AXIS_DATA_WIDTH-1:0]           m_resp_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]           m_resp_tkeep,
  output logic                                 m_resp_tlast,
  output logic                                 m_resp_tuser,
  output logic [NUM_REQ-1:0]                   m_resp_tvalid,
  input  logic [NUM_REQ-1:0]                   m_resp_tready,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id,
  output logic                                 grant_active,
  output logic [$clog2(ID_FIFO_DEPTH):0]       outstanding
);

  // Handshake: a beat transfers on a rising edge where tvalid and tready are both high;
  // valid never waits on ready, and ready is a pure function of state plus the downstream ready.

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(ID_FIFO_DEPTH);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FWD  = 1'b1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic [0:0]           state;
  logic [ID_W-1:0]      last_id;
  logic [ID_W-1:0]      pick_id;
  logic [ID_W-1:0]      cand_id;
  logic                 pick_valid;
  logic [ID_W-1:0]      id_mem [ID_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 req_done;
  logic [ID_W-1:0]      head_id;
  logic [AXIS_DATA_WIDTH-1:0] req_data [NUM_REQ];
  logic [AXIS_KEEP_WIDTH-1:0] req_keep [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_data[g] = s_req_tdata[g*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    assign req_keep[g] = s_req_tkeep[g*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
  end

  // Scan from the farthest candidate down so the nearest requester after last_id wins.
  always_comb begin
    pick_id    = last_id;
    pick_valid = 1'b0;
    cand_id    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_id = ID_W'((int'(last_id) + k) % NUM_REQ);
      if (s_req_tvalid[cand_id]) begin
        pick_id    = cand_id;
        pick_valid = 1'b1;
      end
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PTR_W+1)'(ID_FIFO_DEPTH));
  assign head_id    = id_mem[rd_ptr];
  assign push       = (state == ST_IDLE) && pick_valid && !fifo_full;
  assign req_done   = (state == ST_FWD) && m_req_tvalid && m_req_tready && m_req_tlast;

  always_comb begin
    m_req_tdata  = req_data[grant_id];
    m_req_tkeep  = req_keep[grant_id];
    m_req_tlast  = s_req_tlast[grant_id];
    m_req_tuser  = s_req_tuser[grant_id];
    m_req_tvalid = (state == ST_FWD) && s_req_tvalid[grant_id];
    s_req_tready = '0;
    if (state == ST_FWD) s_req_tready[grant_id] = m_req_tready;
  end

  // Responses with no outstanding command stall rather than being dropped.
  assign m_resp_tdata  = s_resp_tdata;
  assign m_resp_tkeep  = s_resp_tkeep;
  assign m_resp_tlast  = s_resp_tlast;
  assign m_resp_tuser  = s_resp_tuser;
  assign m_resp_tvalid = fifo_empty ? '0 : ((ONE_HOT0 << head_id) & {NUM_REQ{s_resp_tvalid}});
  assign s_resp_tready = !fifo_empty && m_resp_tready[head_id];
  assign pop           = s_resp_tvalid && s_resp_tready && s_resp_tlast;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      grant_id <= '0;
      last_id  <= ID_W'(NUM_REQ - 1);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (push) begin
          grant_id <= pick_id;
          state    <= ST_FWD;
        end
        ST_FWD: if (req_done) begin
          last_id <= grant_id;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) id_mem[wr_ptr] <= pick_id;
  end

  assign grant_active = (state == ST_FWD);
  assign outstanding  = count;

endmodule
